// File: rtl/gtv_pkg.sv
// gtv_pkg: shared mode-bit indices and encodings for the game timer/score counter
package gtv_pkg;
    localparam int MODE_SRC = 2;
    localparam int MODE_SAT = 1;
    localparam int MODE_DIR = 0;
    localparam logic SRC_TIMER = 1'b0;
    localparam logic SRC_EVENT = 1'b1;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/gtv_counter_ctl_if.sv
// gtv_counter_ctl_if: control/status bundle between the game FSM (master) and the counter (slave)
interface gtv_counter_ctl_if #(parameter int CNT_W = 8);
    logic en;
    logic spd_btn;
    logic spd_clr;
    logic [2:0] mode;
    logic evnt;
    logic load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] count;
    logic tick;
    logic tc;
    modport master (
        output en, spd_btn, spd_clr, mode, evnt, load, load_val, limit,
        input count, tick, tc
    );
    modport slave (
        input en, spd_btn, spd_clr, mode, evnt, load, load_val, limit,
        output count, tick, tc
    );
endinterface

// File: rtl/gtv_tick_gen.sv
// gtv_tick_gen: speed-adjustable tick period generator (accumulator, period adder, base divider)
module gtv_tick_gen #(
    parameter int BASE_DIV = 250000,
    parameter int DIV_W = 25,
    parameter int SPD_W = 29,
    parameter int SPD_SHIFT = 4
) (
    input logic clk,
    input logic rst,
    input logic spd_btn,
    input logic spd_clr,
    output logic tick_int,
    output logic tick
);
    localparam int PW = DIV_W + 1;
    if (PW < SPD_W - SPD_SHIFT + 1) begin : g_width_chk
        $error("gtv_tick_gen: DIV_W+1 too narrow for shifted speed accumulator");
    end
    if (BASE_DIV < 2) begin : g_div_chk
        $error("gtv_tick_gen: BASE_DIV must be at least 2");
    end
    logic [SPD_W-1:0] acc_q, acc_d;
    logic [PW-1:0] div_q, div_d, period;
    logic tick_q, tick_d;
    always_comb begin
        acc_d = spd_clr ? '0 : (spd_btn && !(&acc_q)) ? acc_q + SPD_W'(1) : acc_q;
        period = PW'(BASE_DIV) + PW'(acc_q >> SPD_SHIFT);
        // >= rather than == so a shrinking period wraps at once instead of running the divider round
        tick_int = div_q >= period - PW'(1);
        div_d = tick_int ? '0 : div_q + PW'(1);
        tick_d = tick_int;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            div_q <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            div_q <= div_d;
            tick_q <= tick_d;
        end
    end
    assign tick = tick_q;
endmodule

// File: rtl/gtv_counter_ctl.sv
// gtv_counter_ctl: up/down wrap/saturate counter stepped by timer ticks or synchronized events,
// with load, enable, programmable limit and a terminal-count pulse.
module gtv_counter_ctl
    import gtv_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int BASE_DIV = 250000,
    parameter int DIV_W = 25,
    parameter int SPD_W = 29,
    parameter int SPD_SHIFT = 4
) (
    input logic clk,
    input logic rst,
    gtv_counter_ctl_if.slave bus
);
    logic [2:0] sync_q, sync_d;
    logic [CNT_W-1:0] count_q, count_d, nxt;
    logic tc_q, tc_d;
    logic tick_int, tick, ev_edge, step, up, sat, at_term;
    gtv_tick_gen #(
        .BASE_DIV(BASE_DIV),
        .DIV_W(DIV_W),
        .SPD_W(SPD_W),
        .SPD_SHIFT(SPD_SHIFT)
    ) u_tick (
        .clk(clk),
        .rst(rst),
        .spd_btn(bus.spd_btn),
        .spd_clr(bus.spd_clr),
        .tick_int(tick_int),
        .tick(tick)
    );
    always_comb begin
        // two synchronizer stages plus one history stage for edge detection
        sync_d = {sync_q[1:0], bus.evnt};
        ev_edge = sync_q[1] & ~sync_q[2];
        up = bus.mode[MODE_DIR] == DIR_UP;
        sat = bus.mode[MODE_SAT];
        step = bus.en & ((bus.mode[MODE_SRC] == SRC_EVENT) ? ev_edge : tick_int);
        at_term = up ? (count_q >= bus.limit) : (count_q == '0);
        nxt = up ? (at_term ? (sat ? bus.limit : '0) : count_q + CNT_W'(1))
                 : (at_term ? (sat ? '0 : bus.limit) : count_q - CNT_W'(1));
        count_d = bus.load ? bus.load_val : step ? nxt : count_q;
        tc_d = !bus.load && step && at_term;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            count_q <= '0;
            tc_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            count_q <= count_d;
            tc_q <= tc_d;
        end
    end
    assign bus.count = count_q;
    assign bus.tick = tick;
    assign bus.tc = tc_q;
endmodule

// File: tb/tb_gtv_counter_ctl.sv
// tb_gtv_counter_ctl: table-driven timer-mode checks plus directed speed, event, and reset sequences
module tb_gtv_counter_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    always #5 clk = ~clk;
    gtv_counter_ctl_if #(.CNT_W(4)) bus ();
    gtv_counter_ctl #(
        .CNT_W(4),
        .BASE_DIV(4),
        .DIV_W(3),
        .SPD_W(4),
        .SPD_SHIFT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    typedef struct {
        int cyc;
        logic en;
        logic ld;
        logic [3:0] ld_val;
        logic [2:0] mode;
        logic [3:0] lim;
        logic [3:0] e_cnt;
        logic e_tick;
        logic e_tc;
    } vec_t;
    vec_t tbl[25];
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic wait_tick(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (bus.tick) begin
                n = i;
                break;
            end
        end
    endtask
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500000");
        $fatal(1);
    end
    initial begin
        int n;
        tbl[0]  = '{3, 1, 0, 0, 3'b001, 5, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 3'b001, 5, 1, 1, 0};
        tbl[2]  = '{1, 1, 0, 0, 3'b001, 5, 1, 0, 0};
        tbl[3]  = '{3, 1, 0, 0, 3'b001, 5, 2, 1, 0};
        tbl[4]  = '{4, 1, 0, 0, 3'b001, 5, 3, 1, 0};
        tbl[5]  = '{4, 1, 0, 0, 3'b001, 5, 4, 1, 0};
        tbl[6]  = '{4, 1, 0, 0, 3'b001, 5, 5, 1, 0};
        tbl[7]  = '{4, 1, 0, 0, 3'b001, 5, 0, 1, 1};
        tbl[8]  = '{1, 1, 0, 0, 3'b001, 5, 0, 0, 0};
        tbl[9]  = '{1, 1, 1, 2, 3'b010, 5, 2, 0, 0};
        tbl[10] = '{2, 1, 0, 0, 3'b010, 5, 1, 1, 0};
        tbl[11] = '{4, 1, 0, 0, 3'b010, 5, 0, 1, 0};
        tbl[12] = '{4, 1, 0, 0, 3'b010, 5, 0, 1, 1};
        tbl[13] = '{1, 1, 0, 0, 3'b010, 5, 0, 0, 0};
        tbl[14] = '{3, 1, 0, 0, 3'b010, 5, 0, 1, 1};
        tbl[15] = '{3, 1, 0, 0, 3'b001, 5, 0, 0, 0};
        tbl[16] = '{1, 1, 1, 9, 3'b001, 5, 9, 1, 0};
        tbl[17] = '{4, 0, 0, 0, 3'b001, 5, 9, 1, 0};
        tbl[18] = '{4, 0, 0, 0, 3'b001, 5, 9, 1, 0};
        tbl[19] = '{4, 1, 0, 0, 3'b000, 5, 8, 1, 0};
        tbl[20] = '{1, 1, 1, 0, 3'b000, 5, 0, 0, 0};
        tbl[21] = '{3, 1, 0, 0, 3'b000, 5, 5, 1, 1};
        tbl[22] = '{1, 1, 1, 0, 3'b001, 0, 0, 0, 0};
        tbl[23] = '{3, 1, 0, 0, 3'b001, 0, 0, 1, 1};
        tbl[24] = '{1, 0, 1, 3, 3'b001, 0, 3, 0, 0};
        bus.en = 1'b1;
        bus.spd_btn = 1'b0;
        bus.spd_clr = 1'b0;
        bus.mode = 3'b001;
        bus.evnt = 1'b0;
        bus.load = 1'b0;
        bus.load_val = '0;
        bus.limit = 4'd5;
        @(negedge clk);
        chk("reset_count", bus.count, 0);
        chk("reset_tick", bus.tick, 0);
        chk("reset_tc", bus.tc, 0);
        do_reset();
        for (int i = 0; i < 25; i++) begin
            bus.en = tbl[i].en;
            bus.load = tbl[i].ld;
            bus.load_val = tbl[i].ld_val;
            bus.mode = tbl[i].mode;
            bus.limit = tbl[i].lim;
            repeat (tbl[i].cyc) @(negedge clk);
            chk($sformatf("row%0d_count", i), bus.count, tbl[i].e_cnt);
            chk($sformatf("row%0d_tick", i), bus.tick, tbl[i].e_tick);
            chk($sformatf("row%0d_tc", i), bus.tc, tbl[i].e_tc);
        end
        bus.load = 1'b0;
        // speed: acc=4 -> period 6; clear with divider at 5 -> immediate wrap, then period 4
        do_reset();
        bus.en = 1'b0;
        bus.spd_btn = 1'b1;
        repeat (4) @(negedge clk);
        bus.spd_btn = 1'b0;
        wait_tick(20, n);
        chk("spd_sync", n > 0 ? 1 : 0, 1);
        wait_tick(20, n);
        chk("spd_gap6_a", n, 6);
        wait_tick(20, n);
        chk("spd_gap6_b", n, 6);
        repeat (4) @(negedge clk);
        bus.spd_clr = 1'b1;
        @(negedge clk);
        bus.spd_clr = 1'b0;
        chk("clr_pre_tick", bus.tick, 0);
        @(negedge clk);
        chk("clr_tick", bus.tick, 1);
        wait_tick(20, n);
        chk("clr_gap4", n, 4);
        bus.spd_btn = 1'b1;
        repeat (20) @(negedge clk);
        bus.spd_btn = 1'b0;
        wait_tick(30, n);
        chk("sat_sync", n > 0 ? 1 : 0, 1);
        wait_tick(30, n);
        chk("acc_sat_gap11", n, 11);
        bus.spd_clr = 1'b1;
        @(negedge clk);
        bus.spd_clr = 1'b0;
        // event source: count changes two edges after the rise; a held level counts once
        bus.mode = 3'b101;
        bus.limit = 4'd15;
        bus.en = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        chk("ev_idle", bus.count, 0);
        for (int i = 0; i < 3; i++) begin
            bus.evnt = 1'b1;
            repeat (2) @(negedge clk);
            chk($sformatf("ev%0d_before", i), bus.count, i);
            @(negedge clk);
            chk($sformatf("ev%0d_after", i), bus.count, i + 1);
            repeat (2) @(negedge clk);
            bus.evnt = 1'b0;
            repeat (5) @(negedge clk);
        end
        bus.evnt = 1'b1;
        repeat (20) @(negedge clk);
        chk("ev_hold", bus.count, 4);
        bus.evnt = 1'b0;
        repeat (5) @(negedge clk);
        chk("ev_hold_after", bus.count, 4);
        // async reset mid-count with evnt held high through release
        bus.en = 1'b0;
        bus.mode = 3'b001;
        bus.load_val = 4'd7;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        bus.spd_btn = 1'b1;
        repeat (9) @(negedge clk);
        bus.spd_btn = 1'b0;
        chk("pre_rst_count", bus.count, 7);
        #2;
        rst = 1'b1;
        bus.evnt = 1'b1;
        bus.mode = 3'b101;
        bus.en = 1'b1;
        #1;
        chk("arst_count", bus.count, 0);
        chk("arst_tick", bus.tick, 0);
        chk("arst_tc", bus.tc, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_evnt_once", bus.count, 1);
        wait_tick(20, n);
        wait_tick(20, n);
        chk("rst_acc_gap4", n, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/gtv_counter_ctl.md
Name: gtv_counter_ctl

Overview:
- Parametrised successor of the game-timer/score counter.
- Counts one step per timer tick or per `evnt` rising edge, up or down, with a software-adjustable tick period.
- Adds wrap/saturate modes, programmable limit, synchronous load, enable and a terminal-count pulse.
- Sits between the game FSM (mode, load, events) and the display/score logic (count, tc).

Parameters:
- CNT_W, 8, counter width.
- BASE_DIV, 250000, nominal tick period in clk cycles (≥2).
- DIV_W, 25, width of BASE_DIV; base divider and period are DIV_W+1 bits.
- SPD_W, 29, speed accumulator width.
- SPD_SHIFT, 4, accumulator right-shift applied before adding to the period.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count enable; low holds count (tick generator keeps running)
- spd_btn  in  1  while high, speed accumulator +1 per cycle
- spd_clr  in  1  synchronous clear of speed accumulator
- mode  in  3  [2]=source (0 timer, 1 event), [1]=sat (1 saturate, 0 wrap), [0]=dir (1 up, 0 down)
- evnt  in  1  asynchronous event input
- load  in  1  synchronous load strobe
- load_val  in  CNT_W  value loaded on load
- limit  in  CNT_W  upper terminal value
- count  out  CNT_W  registered counter value
- tick  out  1  registered one-cycle pulse per tick period
- tc  out  1  registered one-cycle terminal-count pulse

Behaviour:
- Reset (async): count=0, tick=0, tc=0, speed accumulator=0, base divider=0, sync/edge flops=0.
- Speed accumulator:
  - +1 per cycle with spd_btn; saturates at all-ones (no wrap).
  - spd_clr has priority over increment.
- Period: period = BASE_DIV + (acc >> SPD_SHIFT), computed in DIV_W+1 bits.
  - Width rule: DIV_W+1 ≥ SPD_W-SPD_SHIFT+1 is required; an elaboration check fails otherwise.
- Base divider and tick:
  - Divider counts 0..period-1, then returns to 0.
  - tick asserts for one cycle on the cycle after the divider's terminal compare (registered).
  - Compare is divider ≥ period-1, so a period shrink via spd_clr wraps immediately with no long miss.
- Event path:
  - evnt passes through a 2-flop synchronizer plus one history flop; rising edge = s2 & ~s3.
  - An evnt rise meeting setup before edge k changes count at edge k+2.
  - evnt held high across reset release counts exactly once.
- Step source: step = en & (mode[2] ? event_edge : tick_internal). tick_internal is the unregistered compare, so count updates on the same edge that tick rises.
- Update priority: load > step > hold.
  - load: count <= load_val; tc not asserted. load is honoured even when en=0.
- Up step (dir=1):
  - count < limit: count+1.
  - count ≥ limit: wrap mode → 0; sat mode → limit.
- Down step (dir=0):
  - count > 0: count-1. This also applies when count > limit.
  - count == 0: wrap mode → limit; sat mode → 0.
- tc: registered high for one cycle whenever a step occurs while count is at its terminal value (≥limit going up, 0 going down), in both wrap and sat modes.
- limit=0:
  - Up: count stays 0 and tc pulses every step.
  - Down: same.
- Mode change takes effect on the next step; no state is flushed.
- Arithmetic is modulo CNT_W only where explicitly wrapped above; no other overflow paths exist.

Decomposition:
- Package gtv_pkg:
  - Mode bit indices MODE_SRC=2, MODE_SAT=1, MODE_DIR=0.
  - Constants SRC_TIMER/SRC_EVENT, DIR_UP/DIR_DOWN.
- Sub-module gtv_tick_gen:
  - Contains the speed accumulator, period adder, base divider and tick register.
  - Parameters BASE_DIV, DIV_W, SPD_W, SPD_SHIFT.
  - Outputs tick_int (comb) and tick (reg).
- Top gtv_counter_ctl holds the synchronizer/edge detector, step logic, count and tc registers.

Test Plan:
- Bench parameters: BASE_DIV=4, DIV_W=3, SPD_W=4, SPD_SHIFT=1, CNT_W=4.
- Timer up/wrap: mode=3'b001, limit=5, en=1 from reset -> tick every 4 cycles; count 1,2,3,4,5,0; tc one cycle on the 5→0 step only.
- Timer down/sat: load_val=2, load pulse, mode=3'b010 -> count 2,1,0,0…; tc pulses at each step taken while at 0.
- Speed: hold spd_btn 4 cycles (acc=4, extra=2) -> tick spacing 6 cycles; then spd_clr mid-period with divider=5 -> tick next cycle, then spacing 4.
- Event up: mode=3'b101, limit=15, three evnt pulses 5 cycles wide, spaced 10 -> count 1,2,3, each change 2 edges after evnt rise; holding evnt high 20 cycles -> one increment only.
- Priority and enable: load with simultaneous tick -> count=load_val, no tc; en=0 with ticks -> count held, tick still pulses.
- Async reset mid-count (count=7, acc=9) -> all outputs 0 immediately; evnt held high through release -> exactly one increment in mode 3'b101.
